ic_mem_responder: RTL and testbench
===================================

// Module: ic_mem_responder
// PURPOSE
//  Memory-side responder for the icache line-fill interface. Accepts 128-bit
//  line read requests (address + 2-bit transaction id), holds them in an
//  in-order queue and returns each line after a fixed latency, tagged with
//  the request's xid. Line data comes from an internal preloadable line RAM.
//  Used as the synthesizable memory model behind ic_top in bring-up and
//  simulation benches.
// PARAMETERS
//  DEPTH    4   outstanding request queue entries (power of 2, >=2)
//  LAT      4   request-accept to response-valid latency in cycles (>=2, <=15)
//  LINE_AW  8   line RAM index width; RAM holds 2**LINE_AW 128-bit lines
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        asynchronous reset, active-high
//  ic_mem_addr    in   23       request line address [26:4]; RAM index = bits [LINE_AW+3:4]
//  ic_mem_xid     in   2        request transaction id
//  ic_mem_re      in   1        request strobe
//  mem_ic_ready   out  1        responder can accept a request this cycle
//  mem_ic_valid   out  1        response data valid (single-cycle pulse per request)
//  mem_ic_xid     out  2        xid of the returned line
//  mem_ic_data    out  128      returned line data
//  ld_we          in   1        preload write enable
//  ld_addr        in   LINE_AW  preload line index
//  ld_data        in   128      preload line data
// BEHAVIOUR
//  - Reset (async assert, sync release): queue emptied, age counters cleared,
//    mem_ic_ready=0 while rst=1 and =1 from the first clock after release,
//    mem_ic_valid=0, mem_ic_xid=0, mem_ic_data=0. Line RAM is NOT reset.
//  - Accept: request taken at an edge where ic_mem_re && mem_ic_ready.
//    mem_ic_ready = (count < DEPTH), from registered count only; when full, a
//    same-cycle pop does not enable an accept.
//  - Each entry stores {line index, xid, age}; age=0 at accept, increments
//    every cycle, saturates at LAT.
//  - Pop: head pops when its age reaches the issue threshold (LAT-1). RAM is
//    read at the pop edge; mem_ic_valid/xid/data are registered, so a request
//    accepted at edge T yields mem_ic_valid=1 during cycle T+LAT when uncontended.
//  - Ordering: strictly in order, at most one response per cycle. Back-to-back
//    accepts give back-to-back valid pulses. No response backpressure.
//  - mem_ic_data/xid hold their last value when mem_ic_valid=0.
//  - Simultaneous accept and pop: count unchanged; both happen.
//  - Preload write and pop to the same line in the same edge: the response
//    carries the OLD line (read-before-write); the write lands.
//  - ic_mem_re while not ready: ignored, no state change, no error.
//  - Reset mid-operation: all queued requests discarded, no responses issued
//    for them.
// CONFIGURATION
//  IC_MEM_RSP_JITTER_EN defined: an 8-bit Fibonacci LFSR (seed 8'h01 at
//    reset, taps 8,6,5,4) advances every cycle. On each pop, LFSR[1:0] is
//    added as extra wait: head must reach age LAT-1+jitter (age saturation
//    raised to LAT+3). Ordering and the one-per-cycle rule are unchanged.
//  Not defined: no LFSR; latency is exactly LAT as above.
// TESTING
//  1 Reset: hold rst 3 cycles, release -> ready=1 next cycle, valid=0, data=0, xid=0.
//  2 Preload line 5 = 128'hA5A5..A5; request addr[26:4]=23'h5, xid=2 at edge
//    T -> valid only in cycle T+4, xid=2, data=128'hA5A5..A5.
//  3 Issue 4 requests on consecutive edges with re held (xid 0,1,2,3), no
//    pops yet -> ready=0 after 4th accept; 5th re ignored; 4 valid pulses in
//    consecutive cycles in xid order 0,1,2,3; ready returns to 1.
//  4 Preload write to line 7 on the same edge line 7 pops -> response shows
//    old value; a following request to line 7 returns the new value.
//  5 Accept 3 requests, assert rst for 1 cycle mid-flight -> no valid pulses
//    for them; fresh request after release returns at T+LAT.
//  6 With IC_MEM_RSP_JITTER_EN: 16 back-to-back requests -> every latency in
//    [LAT, LAT+3] plus queueing delay, xids returned in issue order, same data
//    as the non-jitter build.

Source files
------------

// File: rtl/ic_mem_responder.sv
// In-order icache line-fill responder: queued line reads return LAT cycles after accept, one per cycle, no response backpressure.
// Request side throttled by mem_ic_ready (queue not full); IC_MEM_RSP_JITTER_EN adds an LFSR-driven 0..3 cycle extra wait per pop.
module ic_mem_responder #(
  parameter int DEPTH   = 4,
  parameter int LAT     = 4,
  parameter int LINE_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [22:0]        ic_mem_addr,
  input  logic [1:0]         ic_mem_xid,
  input  logic               ic_mem_re,
  output logic               mem_ic_ready,
  output logic               mem_ic_valid,
  output logic [1:0]         mem_ic_xid,
  output logic [127:0]       mem_ic_data,
  input  logic               ld_we,
  input  logic [LINE_AW-1:0] ld_addr,
  input  logic [127:0]       ld_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] THR = 5'(LAT - 1);
`ifdef IC_MEM_RSP_JITTER_EN
  localparam logic [4:0] AGE_MAX = 5'(LAT + 3);
`else
  localparam logic [4:0] AGE_MAX = 5'(LAT);
`endif

  logic [127:0]       r_mem  [0:(1<<LINE_AW)-1];
  logic [LINE_AW-1:0] r_idx  [DEPTH];
  logic [1:0]         r_qxid [DEPTH];
  logic [4:0]         r_age  [DEPTH];
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_live;
  logic               r_vld;
  logic [1:0]         r_xid;
  logic [127:0]       r_dat;
  logic               w_acc;
  logic               w_pop;
  logic [4:0]         w_thr;
  logic               w_unused;

  // Only the RAM index bits of the line address are meaningful here.
  assign w_unused     = ^ic_mem_addr[22:LINE_AW];
  assign mem_ic_ready = r_live && (r_cnt < CW'(DEPTH));
  assign w_acc        = ic_mem_re && mem_ic_ready;
  assign w_pop        = (r_cnt != '0) && (r_age[r_rp] >= w_thr);
  assign mem_ic_valid = r_vld;
  assign mem_ic_xid   = r_xid;
  assign mem_ic_data  = r_dat;

`ifdef IC_MEM_RSP_JITTER_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_thr = THR + {3'b000, r_lfsr[1:0]};
`else
  assign w_thr = THR;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i]  <= '0;
        r_qxid[i] <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_live <= 1'b1;
      // Stale slots keep aging too; a fresh accept overwrites its slot's age.
      for (int i = 0; i < DEPTH; i++) begin
        if (r_age[i] < AGE_MAX) r_age[i] <= r_age[i] + 5'd1;
      end
      if (w_acc) begin
        r_idx[r_wp]  <= ic_mem_addr[LINE_AW-1:0];
        r_qxid[r_wp] <= ic_mem_xid;
        r_age[r_wp]  <= '0;
        r_wp         <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (w_acc && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_acc && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_xid <= '0;
      r_dat <= '0;
    end else begin
      r_vld <= w_pop;
      if (w_pop) begin
        r_xid <= r_qxid[r_rp];
        r_dat <= r_mem[r_idx[r_rp]];
      end
    end
  end

  // Same-edge preload and pop: the pop sees the old line.
  always_ff @(posedge clk) begin
    if (ld_we) r_mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_ic_mem_responder.sv
// Bench for ic_mem_responder: due-time queue reference model plus directed scenario tasks.
module tb_ic_mem_responder;
  localparam int DEPTH   = 4;
  localparam int LAT     = 4;
  localparam int LINE_AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [22:0] ic_mem_addr = '0;
  logic [1:0] ic_mem_xid = '0;
  logic ic_mem_re = 1'b0;
  logic mem_ic_ready;
  logic mem_ic_valid;
  logic [1:0] mem_ic_xid;
  logic [127:0] mem_ic_data;
  logic ld_we = 1'b0;
  logic [LINE_AW-1:0] ld_addr = '0;
  logic [127:0] ld_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ic_mem_responder #(.DEPTH(DEPTH), .LAT(LAT), .LINE_AW(LINE_AW)) dut (
    .clk(clk), .rst(rst),
    .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid), .ic_mem_re(ic_mem_re),
    .mem_ic_ready(mem_ic_ready), .mem_ic_valid(mem_ic_valid),
    .mem_ic_xid(mem_ic_xid), .mem_ic_data(mem_ic_data),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // Reference model: each accepted request is due LAT edges after its accept
  // edge; the oldest pending request leaves at the first edge at or after its
  // due time, one per edge, reading the line as it was before that edge.
  typedef struct {
    logic [LINE_AW-1:0] idx;
    logic [1:0]         xid;
    int                 due;
  } req_t;

  req_t q[$];
  logic [127:0] mram [0:(1<<LINE_AW)-1];
  int cyc = 0;
  int m_acc = 0;
  int m_j = 0;
  bit m_live = 1'b0;
  bit m_acc_now = 1'b0;
  logic e_vld = 1'b0;
  logic [1:0] e_xid = '0;
  logic [127:0] e_dat = '0;
`ifdef IC_MEM_RSP_JITTER_EN
  logic [7:0] m_lfsr = 8'h01;
`endif

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      m_live = 1'b0;
      e_vld = 1'b0;
      e_xid = '0;
      e_dat = '0;
`ifdef IC_MEM_RSP_JITTER_EN
      m_lfsr = 8'h01;
`endif
    end else begin
      m_j = 0;
`ifdef IC_MEM_RSP_JITTER_EN
      m_j = int'(m_lfsr[1:0]);
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
      m_acc_now = ic_mem_re && m_live && (q.size() < DEPTH);
      e_vld = 1'b0;
      if (q.size() > 0 && cyc >= q[0].due + m_j) begin
        e_vld = 1'b1;
        e_xid = q[0].xid;
        e_dat = mram[q[0].idx];
        void'(q.pop_front());
      end
      if (ld_we) mram[ld_addr] = ld_data;
      if (m_acc_now) begin
        q.push_back('{ic_mem_addr[LINE_AW-1:0], ic_mem_xid, cyc + LAT});
        m_acc++;
      end
      m_live = 1'b1;
    end
  end

  function automatic bit exp_rdy();
    return m_live && !rst && (q.size() < DEPTH);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_hold rdy=%b vld=%b, required rdy=0 vld=0", mem_ic_ready, mem_ic_valid);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {1'b1, 1'b0, 2'b00, 128'h0}) begin
      n_fail++;
      $display("FAIL reset_release rdy=%b vld=%b xid=%0d dat=%h, required rdy=1 vld=0 xid=0 dat=0",
               mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data);
    end
  endtask

  task automatic preload_all();
    for (int i = 0; i < (1 << LINE_AW); i++) begin
      ld_we = 1'b1;
      ld_addr = LINE_AW'(i);
      ld_data = rand128();
      @(negedge clk);
    end
    ld_we = 1'b0;
  endtask

  task automatic test_single();
    int t_acc, n_v, v_cyc;
    logic [1:0] v_xid;
    logic [127:0] v_dat;
    n_v = 0; v_cyc = 0; v_xid = '0; v_dat = '0;
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = {16{8'hA5}};
    @(negedge clk);
    ld_we = 1'b0; ic_mem_re = 1'b1; ic_mem_addr = 23'h5; ic_mem_xid = 2'd2;
    t_acc = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ic_mem_re = 1'b0;
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
        n_fail++;
        $display("FAIL single_model cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                 cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
      end
      if (mem_ic_valid) begin
        n_v++; v_cyc = cyc; v_xid = mem_ic_xid; v_dat = mem_ic_data;
      end
    end
    n_chk++;
    if (n_v !== 1) begin
      n_fail++;
      $display("FAIL single_count pulses=%0d, required 1", n_v);
    end
`ifndef IC_MEM_RSP_JITTER_EN
    n_chk++;
    if (v_cyc - t_acc !== LAT) begin
      n_fail++;
      $display("FAIL single_latency got %0d, required %0d", v_cyc - t_acc, LAT);
    end
`endif
    n_chk++;
    if ({v_xid, v_dat} !== {2'd2, {16{8'hA5}}}) begin
      n_fail++;
      $display("FAIL single_data xid=%0d dat=%h, required xid=2 dat=a5..a5", v_xid, v_dat);
    end
  endtask

  task automatic test_full();
    int t_acc;
    int v_cyc[$];
    logic [1:0] v_xid[$];
    ic_mem_re = 1'b1; ic_mem_xid = 2'd0; ic_mem_addr = 23'($urandom);
    t_acc = cyc + 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
        n_fail++;
        $display("FAIL full_model cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                 cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
      end
      if (mem_ic_valid) begin
        v_cyc.push_back(cyc);
        v_xid.push_back(mem_ic_xid);
      end
      if (i == 3) begin
        n_chk++;
        if (mem_ic_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready rdy=%b after 4 accepts, required 0", mem_ic_ready);
        end
      end
      ic_mem_re = (i < 4);
      ic_mem_xid = 2'(i + 1);
      ic_mem_addr = 23'($urandom);
    end
    n_chk++;
    if (v_xid.size() !== 4) begin
      n_fail++;
      $display("FAIL full_count pulses=%0d, required 4", v_xid.size());
    end
    for (int k = 0; k < v_xid.size(); k++) begin
      n_chk++;
      if (v_xid[k] !== 2'(k)) begin
        n_fail++;
        $display("FAIL full_order pulse %0d xid=%0d, required %0d", k, v_xid[k], k);
      end
`ifndef IC_MEM_RSP_JITTER_EN
      n_chk++;
      if (v_cyc[k] !== t_acc + LAT + k) begin
        n_fail++;
        $display("FAIL full_timing pulse %0d cyc=%0d, required %0d", k, v_cyc[k], t_acc + LAT + k);
      end
`endif
    end
    n_chk++;
    if (mem_ic_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_back rdy=%b, required 1", mem_ic_ready);
    end
  endtask

  task automatic test_rbw();
    logic [127:0] old_v, new_v;
    logic [127:0] got[$];
    int t_acc;
    old_v = rand128();
    new_v = ~old_v;
    ld_we = 1'b1; ld_addr = 8'd7; ld_data = old_v;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      ld_we = 1'b0; ic_mem_re = 1'b1; ic_mem_xid = 2'(r + 1);
      ic_mem_addr = {15'($urandom), 8'd7};
      t_acc = cyc + 1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        n_chk++;
        if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
          n_fail++;
          $display("FAIL rbw_model cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                   cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
        end
        if (mem_ic_valid) got.push_back(mem_ic_data);
        ic_mem_re = 1'b0;
        // First round: overwrite line 7 on the edge the request pops.
        ld_we = (r == 0) && (cyc == t_acc + LAT - 1);
        ld_addr = 8'd7;
        ld_data = new_v;
      end
    end
    ld_we = 1'b0;
    n_chk++;
    if (got.size() !== 2) begin
      n_fail++;
      $display("FAIL rbw_count pulses=%0d, required 2", got.size());
    end
    n_chk++;
    if (got[0] !== old_v) begin
      n_fail++;
      $display("FAIL rbw_old got %h, required %h", got[0], old_v);
    end
    n_chk++;
    if (got[1] !== new_v) begin
      n_fail++;
      $display("FAIL rbw_new got %h, required %h", got[1], new_v);
    end
  endtask

  task automatic test_reset_mid();
    int n_v, t_acc, v_cyc;
    n_v = 0; v_cyc = 0;
    ic_mem_re = 1'b1; ic_mem_addr = 23'($urandom); ic_mem_xid = 2'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ic_mem_re = (i < 2);
      ic_mem_addr = 23'($urandom);
      ic_mem_xid = 2'($urandom);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mem_ic_ready, mem_ic_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_async rdy=%b vld=%b, required rdy=0 vld=0", mem_ic_ready, mem_ic_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
        n_fail++;
        $display("FAIL rstmid_model cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                 cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
      end
      if (mem_ic_valid) n_v++;
    end
    n_chk++;
    if (n_v !== 0) begin
      n_fail++;
      $display("FAIL rstmid_flushed pulses=%0d, required 0", n_v);
    end
    ic_mem_re = 1'b1; ic_mem_addr = 23'($urandom); ic_mem_xid = 2'd3;
    t_acc = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ic_mem_re = 1'b0;
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
        n_fail++;
        $display("FAIL rstmid_fresh cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                 cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
      end
      if (mem_ic_valid) begin
        n_v++; v_cyc = cyc;
      end
    end
    n_chk++;
    if (n_v !== 1) begin
      n_fail++;
      $display("FAIL rstmid_fresh_count pulses=%0d, required 1", n_v);
    end
`ifndef IC_MEM_RSP_JITTER_EN
    n_chk++;
    if (v_cyc - t_acc !== LAT) begin
      n_fail++;
      $display("FAIL rstmid_fresh_latency got %0d, required %0d", v_cyc - t_acc, LAT);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int start, n_v, budget;
    start = m_acc; n_v = 0; budget = 0;
    // Phase 0: re held until 16 accepts; phase 1: sparse random requests.
    for (int ph = 0; ph < 2; ph++) begin
      while ((ph == 0) ? (m_acc - start < 16 && budget < 200) : (budget < 40)) begin
        ic_mem_re = (ph == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        ic_mem_addr = 23'($urandom);
        ic_mem_xid = 2'($urandom);
        ld_we = ($urandom_range(0, 3) == 0);
        ld_addr = LINE_AW'($urandom);
        ld_data = rand128();
        @(negedge clk);
        budget++;
        n_chk++;
        if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
          n_fail++;
          $display("FAIL b2b_model cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                   cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
        end
        if (mem_ic_valid) n_v++;
      end
      if (ph == 0 && budget >= 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL b2b_timeout accepts=%0d, required 16 within 200 cycles", m_acc - start);
      end
      budget = 0;
    end
    ic_mem_re = 1'b0;
    ld_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data} !== {exp_rdy(), e_vld, e_xid, e_dat}) begin
        n_fail++;
        $display("FAIL b2b_drain cyc=%0d got rdy=%b vld=%b xid=%0d dat=%h, required rdy=%b vld=%b xid=%0d dat=%h",
                 cyc, mem_ic_ready, mem_ic_valid, mem_ic_xid, mem_ic_data, exp_rdy(), e_vld, e_xid, e_dat);
      end
      if (mem_ic_valid) n_v++;
    end
    n_chk++;
    if (n_v !== m_acc - start) begin
      n_fail++;
      $display("FAIL b2b_count pulses=%0d, required %0d", n_v, m_acc - start);
    end
  endtask

  initial begin
    test_reset();
    preload_all();
    test_single();
    test_full();
    test_rbw();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
